board_state_engine: RTL
=======================

// Module: board_state_engine
// PURPOSE
//  Owns the ROWS x COLS lights-out board register and drives its outputs: board_out
//  feeds ScreenValues and mix_state feeds mix_state of the win checker directly downstream.
//  It scrambles the board with LFSR-driven random presses on start.
//  It then applies player presses, each toggling a cell and its 4 orthogonal neighbours.
// PARAMETERS
//  ROWS         4              board rows
//  COLS         8              board columns; N = ROWS*COLS = 32 (board bit width)
//  MIX_PRESSES  64             minimum random presses per scramble
//  INIT_BOARD   32'h0000_FFFF  board value after reset (must not be a win pattern)
//  LFSR_SEED    16'hACE1       LFSR reset value; 0 is replaced by 16'hACE1
//  CNT_W        16             move counter width
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  reset       in   1      synchronous, active-high
//  start       in   1      debounced level; rising edge requests a scramble
//  press       in   1      debounced level; rising edge = one player press
//  cursor_row  in   2      selected row (0..ROWS-1)
//  cursor_col  in   3      selected column (0..COLS-1)
//  board_out   out  N      current board, bit index = row*COLS + col
//  mix_state   out  1      high while scrambling (registered)
//  move_count  out  CNT_W  player presses since last scramble, saturating
// BEHAVIOUR
//  Reset (sync, highest priority, also mid-operation):
//   - board_out=INIT_BOARD, mix_state=0, move_count=0, FSM=IDLE, lfsr=LFSR_SEED
//   - start_q=press_q=0
//  Edge detect:
//   - start_q/press_q register the inputs; an edge is in=1 & q=0 at a posedge
//   - one press edge = exactly one toggle, however long the level is held
//  Toggle mask for idx = r*COLS+c:
//   - bits idx, idx-COLS (r>0), idx+COLS (r<ROWS-1), idx-1 (c>0), idx+1 (c<COLS-1)
//   - no wrap at edges; board_next = board ^ mask
//  LFSR:
//   - 16-bit Fibonacci, taps 16,14,13,11; free-running every cycle after reset
//   - mix index = lfsr[4:0] % N
//  FSM:
//   - IDLE: press ignored. start edge -> MIX, mix_cnt=0, mix_state=1 on the same edge
//   - MIX: every cycle board ^= mask(lfsr index), mix_cnt++; press and start ignored
//     When mix_cnt reaches MIX_PRESSES-1 and board_next is not a win pattern:
//     go to PLAY, mix_state=0, move_count=0, all on the same edge
//     If board_next is a win pattern, keep mixing one more cycle; repeat until it is not
//     Win set: all-0, all-1, 0x5555_5555, 0xAAAA_AAAA
//   - PLAY: press edge with cursor_row<ROWS and cursor_col<COLS
//     -> board ^= mask; move_count+1, saturating at all-ones
//     Out-of-range cursor: no toggle, no count
//     start edge -> MIX, same as from IDLE
//  Latency: board_out updates on the posedge that samples the edge; visible 1 cycle later.
//  Simultaneous start and press edges in PLAY: start wins, the press is dropped.
//  mix_state and board_out change on the same edge, so downstream never sees
//  mix_state=0 with a partially mixed board.
// STRUCTURE
//  game_pkg (shared with the win checker):
//   - ROWS, COLS, N
//   - WIN_PATTERNS constants
//   - function toggle_mask(row, col)
//   - function is_win(board)
//   - FSM state enum IDLE/MIX/PLAY
//  Sub-module lfsr16 (clk, reset, seed, q[15:0]); everything else stays in this module.
// TESTING
//  1 Reset held 2 cycles -> board_out=0000_FFFF, mix_state=0, move_count=0
//  2 start pulse 1 cycle from IDLE -> mix_state=1 on next edge and stays high >=64 cycles
//    -> falls with board_out not in win set; move_count=0
//  3 PLAY, cursor (1,1), press held 10 cycles -> board_out ^= 0002_0702 once; move_count=1
//    Cursor (0,0) -> ^= 0000_0103; cursor (3,7) -> ^= C080_0000
//  4 PLAY, cursor_row=4 (if widened) or press during MIX -> board_out unchanged, move_count unchanged
//  5 PLAY, start and press rise in the same cycle -> MIX entered, no press toggle applied
//  6 reset asserted mid-MIX at cycle 30 -> next cycle board_out=0000_FFFF, mix_state=0, FSM IDLE

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: board geometry, win patterns and press-mask helpers shared by the lights-out blocks
package game_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int N = ROWS * COLS;
  localparam logic [N-1:0] WIN_PATTERNS [4] = '{
    {N{1'b0}},
    {N{1'b1}},
    {(N/2){2'b01}},
    {(N/2){2'b10}}
  };
  typedef enum logic [1:0] {IDLE, MIX, PLAY} state_t;
  function automatic logic [N-1:0] bit_at(input int i);
    return {{(N-1){1'b0}}, 1'b1} << i;
  endfunction
  function automatic logic [N-1:0] toggle_mask(input int r, input int c);
    logic [N-1:0] m;
    m = bit_at(r * COLS + c);
    if (r > 0) m |= bit_at((r - 1) * COLS + c);
    if (r < ROWS - 1) m |= bit_at((r + 1) * COLS + c);
    if (c > 0) m |= bit_at(r * COLS + c - 1);
    if (c < COLS - 1) m |= bit_at(r * COLS + c + 1);
    return m;
  endfunction
  function automatic logic is_win(input logic [N-1:0] b);
    logic w;
    w = 1'b0;
    for (int i = 0; i < 4; i++) w |= (b == WIN_PATTERNS[i]);
    return w;
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  // advance every cycle; an all-zero seed would lock up, so it is swapped for ACE1
  always_ff @(posedge clk)
    if (reset) q <= (seed == 16'h0) ? 16'hACE1 : seed;
    else q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
endmodule

// File: rtl/board_state_engine.sv
// board_state_engine: owns the lights-out board, scrambles it on start and applies player presses
module board_state_engine
  import game_pkg::*;
#(
  parameter int           MIX_PRESSES = 64,
  parameter logic [N-1:0] INIT_BOARD  = 32'h0000_FFFF,
  parameter logic [15:0]  LFSR_SEED   = 16'hACE1,
  parameter int           CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             press,
  input  logic [1:0]       cursor_row,
  input  logic [2:0]       cursor_col,
  output logic [N-1:0]     board_out,
  output logic             mix_state,
  output logic [CNT_W-1:0] move_count
);
  localparam int MW = $clog2(MIX_PRESSES) + 1;
  state_t state, state_next;
  logic [N-1:0] board_next, mix_board;
  logic [CNT_W-1:0] count_next;
  logic [MW-1:0] mix_cnt, mix_cnt_next;
  logic [15:0] lfsr;
  logic start_q, press_q, start_edge, press_edge, mix_done, play_press, unused_lfsr;
  int mix_idx;
  lfsr16 u_lfsr (
    .clk  (clk),
    .reset(reset),
    .seed (LFSR_SEED),
    .q    (lfsr)
  );
  assign unused_lfsr = ^lfsr[15:5];
  assign start_edge = start & ~start_q;
  assign press_edge = press & ~press_q;
  assign mix_idx = int'(lfsr[4:0]) % N;
  assign mix_board = board_out ^ toggle_mask(mix_idx / COLS, mix_idx % COLS);
  assign mix_done = (mix_cnt >= MW'(MIX_PRESSES - 1)) && !is_win(mix_board);
  assign play_press = (state == PLAY) && press_edge && !start_edge &&
                      (int'(cursor_row) < ROWS) && (int'(cursor_col) < COLS);
  // FSM state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_next;
  // start rescrambles from IDLE or PLAY; a scramble ends only on a non-winning board
  always_comb
    state_next = (state != MIX && start_edge) ? MIX :
                 (state == MIX && mix_done) ? PLAY : state;
  // board, move counter and mix counter updates for the current state
  always_comb begin
    board_next = (state == MIX) ? mix_board :
                 play_press ? board_out ^ toggle_mask(int'(cursor_row), int'(cursor_col)) : board_out;
    count_next = (state == MIX && mix_done) ? '0 :
                 (play_press && move_count != '1) ? move_count + 1'b1 : move_count;
    mix_cnt_next = (state != MIX) ? '0 :
                   (mix_cnt < MW'(MIX_PRESSES - 1)) ? mix_cnt + 1'b1 : mix_cnt;
  end
  // registered outputs; mix_state tracks the next state so it moves with the board
  always_ff @(posedge clk)
    if (reset) begin
      board_out <= INIT_BOARD;
      mix_state <= 1'b0;
      move_count <= '0;
      mix_cnt <= '0;
      start_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      board_out <= board_next;
      mix_state <= (state_next == MIX);
      move_count <= count_next;
      mix_cnt <= mix_cnt_next;
      start_q <= start;
      press_q <= press;
    end
endmodule
